muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide controller that owns all writes to the HI/LO register pair for MULT, MULTU, DIV and DIVU.
- Accepts an operation from the decoder with the rs/rt operands.
- Iterates one bit per cycle for 32 cycles while stalling the program counter.
- Writes the 64-bit result to hilo_register in a single cycle.
- Sits between the register file read ports, the decoder and hilo_register, replacing the ALU's direct HI/LO write path for these four ops.

Parameters:
N_ITER, 32, iteration count; must equal the `WORD width; any other value is unsupported.

Ports:
clk_cpu  input  1  CPU clock
reset  input  1  synchronous, active-high reset
start  input  1  decoder asserts for the whole time a mul/div instruction is current
op  input  2  `MD_MULT=0, `MD_MULTU=1, `MD_DIV=2, `MD_DIVU=3
rs  input  `WORD  operand A (multiplicand / dividend)
rt  input  `WORD  operand B (multiplier / divisor)
stall  output  1  holds pc and the instruction while high
busy  output  1  high in RUN and DONE
hilo_wr_en  output  1  one-cycle write strobe to hilo_register
hilo_wr_data  output  `DWORD  {HI,LO}

Behaviour:
Interface:
- One clock (clk_cpu); reset is synchronous and active-high.

Reset:
- Outputs: stall=0, busy=0, hilo_wr_en=0, hilo_wr_data=0.
- State=IDLE, counter=0.
- Reset mid-operation aborts with no HI/LO write.

States: IDLE, RUN, DONE.
- IDLE: stall = start (combinational). If start is high at the edge, latch op, operand magnitudes and result signs; counter=N_ITER-1; go to RUN.
- RUN: stall=1. One iteration per cycle.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring, 1 quotient bit per cycle.
  - Counter decrements each cycle. On counter==0, apply sign fix-up and go to DONE.
- DONE: stall=0; hilo_wr_en=1 with the final hilo_wr_data; return to IDLE next edge. The instruction retires on the same edge as the HI/LO write.
- start seen in RUN or DONE is ignored. This covers the same instruction still held during DONE, so there is no retrigger.

Latency:
- Accept edge E.
- RUN occupies cycles E+1 .. E+32.
- DONE (write) occurs at cycle E+33.
- stall is high for 33 cycles in total.

Signed ops:
- Operate on magnitudes.
- Product is negated when operand signs differ.
- Quotient is negated when signs differ; remainder takes the dividend's sign.

Result mapping:
- Multiply: HI = upper 32 bits, LO = lower 32 bits.
- Divide: HI = remainder, LO = quotient.

Boundary cases:
- Divide by zero (DIV or DIVU): HI=rs, LO=32'hFFFFFFFF. Still takes the full 32 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- op is sampled only at the accept edge; changes during RUN are ignored.
- Operands are sampled only at the accept edge; register writes during RUN are ignored.

Decomposition:
- Shared package (defines.v):
  - `MD_OP (1:0) and `MD_MULT/`MD_MULTU/`MD_DIV/`MD_DIVU.
  - `MD_N_ITER 32.
  - CP_MD_START control-path bit added to `CPATH.
- Sub-module muldiv_step: combinational single iteration.
  - Inputs: mode, accumulator/remainder, operand.
  - Output: next accumulator/remainder and quotient bit.
- The FSM, counter and sign fix-up stay in muldiv_sequencer.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> stall high 33 cycles; hilo_wr_en pulse at E+33 with {HI,LO}=0xFFFFFFFE_00000001.
- MULT rs=-3 rt=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV rs=-7 rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU rs=100 rt=7 -> LO=14, HI=2.
- DIVU rs=0x1234 rt=0 -> HI=0x1234, LO=0xFFFFFFFF, 32 RUN cycles.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- start held through DONE -> exactly one hilo_wr_en pulse.
- Operands changed mid-RUN -> result unaffected.
- reset asserted at RUN cycle 10 -> next cycle IDLE, stall=0, hilo_wr_en never asserted.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
package muldiv_sequencer_pkg;

  localparam int MD_WORD   = 32;
  localparam int MD_DWORD  = 64;
  localparam int MD_N_ITER = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } md_state_e;

  function automatic logic is_div_op(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Decoder / register-file side of the multiply/divide sequencer.
interface muldiv_sequencer_if;
  import muldiv_sequencer_pkg::*;

  logic                 start;
  md_op_e               op;
  logic [MD_WORD-1:0]   rs;
  logic [MD_WORD-1:0]   rt;
  logic                 stall;
  logic                 busy;
  logic                 hilo_wr_en;
  logic [MD_DWORD-1:0]  hilo_wr_data;

  modport master (
    output start, op, rs, rt,
    input  stall, busy, hilo_wr_en, hilo_wr_data
  );

  modport slave (
    input  start, op, rs, rt,
    output stall, busy, hilo_wr_en, hilo_wr_data
  );

endinterface

// File: rtl/muldiv_sequencer_step.sv
// One iteration of shift-add multiply or restoring divide on a 64-bit
// accumulator. Multiply: acc = {partial product, remaining multiplier}.
// Divide: acc = {partial remainder, remaining dividend / quotient bits}.
module muldiv_step
  import muldiv_sequencer_pkg::*;
(
  input  logic                is_div,
  input  logic [MD_DWORD-1:0] acc,
  input  logic [MD_WORD-1:0]  operand,
  output logic [MD_DWORD-1:0] acc_next,
  output logic                q_bit
);

  logic [MD_WORD:0]   sum;
  logic [MD_WORD:0]   rem_sh;
  logic [MD_WORD-1:0] diff;

  // Combinational single step; quotient bit left to the caller to insert.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through it can infer a latch.
    acc_next = '0;
    q_bit    = 1'b0;
    sum      = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? operand : '0)};
    rem_sh   = {acc[63:32], acc[31]};
    // True difference is below the divisor whenever it is used, so 32 bits suffice.
    diff     = rem_sh[MD_WORD-1:0] - operand;
    if (is_div) begin
      q_bit    = (rem_sh >= {1'b0, operand});
      acc_next = {(q_bit ? diff : rem_sh[MD_WORD-1:0]), acc[30:0], 1'b0};
    end else begin
      acc_next = {sum, acc[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller owning all HI/LO writes.
// Stalls the pipeline while iterating, then issues one {HI,LO} write strobe.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int N_ITER = MD_N_ITER
) (
  input  logic          clk_cpu,
  input  logic          reset,
  muldiv_sequencer_if.slave md
);

  localparam int CW = $clog2(N_ITER);

  md_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  md_op_e               op_q;
  logic [MD_DWORD-1:0]  acc_q;
  logic [MD_WORD-1:0]   operand_q;
  logic                 neg_res_q;
  logic                 neg_rem_q;
  logic                 div0_q;
  logic                 wr_en_q;
  logic [MD_DWORD-1:0]  wr_data_q;

  logic [MD_DWORD-1:0]  step_acc;
  logic                 q_bit;
  logic [MD_DWORD-1:0]  acc_nx;
  logic [MD_DWORD-1:0]  result;
  logic                 sign_a;
  logic                 sign_b;
  logic [MD_WORD-1:0]   mag_a;
  logic [MD_WORD-1:0]   mag_b;

  muldiv_step u_step (
    .is_div   (is_div_op(op_q)),
    .acc      (acc_q),
    .operand  (operand_q),
    .acc_next (step_acc),
    .q_bit    (q_bit)
  );

  assign acc_nx = step_acc | {{(MD_DWORD-1){1'b0}}, q_bit};

  // Operand magnitudes and signs as seen at the accept edge.
  always_comb begin
    sign_a = is_signed_op(md.op) & md.rs[MD_WORD-1];
    sign_b = is_signed_op(md.op) & md.rt[MD_WORD-1];
    mag_a  = sign_a ? -md.rs : md.rs;
    mag_b  = sign_b ? -md.rt : md.rt;
  end

  // Sign fix-up of the final iteration's accumulator into {HI,LO}.
  always_comb begin
    result = '0;
    if (is_div_op(op_q)) begin
      result[63:32] = neg_rem_q ? -acc_nx[63:32] : acc_nx[63:32];
      // Divide by zero reports all-ones quotient regardless of signs.
      result[31:0]  = div0_q ? '1 : (neg_res_q ? -acc_nx[31:0] : acc_nx[31:0]);
    end else begin
      result = neg_res_q ? -acc_nx : acc_nx;
    end
  end

  // Control FSM, iteration counter and datapath registers.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; the accumulator/operand registers are left
      // out of reset since they are always loaded at the accept edge.
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wr_en_q <= 1'b0;
          if (md.start) begin
            op_q      <= md.op;
            neg_res_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            div0_q    <= (md.rt == '0);
            if (is_div_op(md.op)) begin
              acc_q     <= {{MD_WORD{1'b0}}, mag_a};
              operand_q <= mag_b;
            end else begin
              acc_q     <= {{MD_WORD{1'b0}}, mag_b};
              operand_q <= mag_a;
            end
            cnt_q   <= CW'(N_ITER - 1);
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q <= acc_nx;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            wr_data_q <= result;
            wr_en_q   <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          wr_en_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign md.stall        = (state_q == ST_IDLE) ? md.start : (state_q == ST_RUN);
  assign md.busy         = (state_q != ST_IDLE);
  assign md.hilo_wr_en   = wr_en_q;
  assign md.hilo_wr_data = wr_data_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed operations with literal
// results plus a cycle-by-cycle comparison against an arithmetic model.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int N = 32;

  logic clk_cpu = 1'b0;
  logic reset;

  muldiv_sequencer_if ifc ();

  muldiv_sequencer #(.N_ITER(N)) dut (
    .clk_cpu (clk_cpu),
    .reset   (reset),
    .md      (ifc.slave)
  );

  always #5 clk_cpu = ~clk_cpu;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result of each operation from plain arithmetic.
  function automatic logic [63:0] model(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      MD_MULT:  p = 64'(sa * sb);
      MD_MULTU: p = {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Model timeline: 0 idle, 1..N iterating, N+1 write cycle.
  int          phase = 0;
  logic [63:0] exp_res = '0;
  int          wr_pulses = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk_cpu) begin
    if (reset) phase <= 0;
    else if (phase == 0) begin
      if (ifc.start === 1'b1) begin
        phase   <= 1;
        exp_res <= model(ifc.op, ifc.rs, ifc.rt);
      end
    end else if (phase == N + 1) phase <= 0;
    else phase <= phase + 1;
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk_cpu) begin
    if (chk_en) begin
      check("busy", 64'(ifc.busy), 64'(phase != 0));
      check("stall", 64'(ifc.stall), 64'((phase == 0) ? ifc.start : (phase <= N)));
      check("hilo_wr_en", 64'(ifc.hilo_wr_en), 64'(phase == N + 1));
      if (phase == N + 1) check("hilo_wr_data", ifc.hilo_wr_data, exp_res);
      if (ifc.hilo_wr_en === 1'b1) wr_pulses <= wr_pulses + 1;
    end
  end

  // Issue one instruction, hold start through the write cycle, check result.
  task automatic run_op(input string name, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input bit disturb);
    int n, stall_n, wr_at, p0;
    logic [63:0] got;
    n = 0; stall_n = 0; wr_at = 0; got = '0;
    p0 = wr_pulses;
    @(posedge clk_cpu); #1;
    ifc.start = 1'b1; ifc.op = op; ifc.rs = a; ifc.rt = b;
    while (wr_at == 0 && n < 100) begin
      @(negedge clk_cpu);
      n++;
      if (ifc.stall === 1'b1) stall_n++;
      if (ifc.hilo_wr_en === 1'b1) begin
        wr_at = n;
        got   = ifc.hilo_wr_data;
      end
      if (disturb && n == 10) begin
        #1;
        ifc.rs = $urandom;
        ifc.rt = $urandom;
        ifc.op = MD_DIVU;
      end
    end
    check({name, " write seen"}, 64'(wr_at != 0), 64'd1);
    check({name, " write cycle"}, 64'(wr_at), 64'(N + 2));
    check({name, " stall cycles"}, 64'(stall_n), 64'(N + 1));
    check({name, " result"}, got, exp);
    @(posedge clk_cpu); #1;
    ifc.start = 1'b0;
    repeat (3) @(negedge clk_cpu);
    check({name, " one pulse"}, 64'(wr_pulses - p0), 64'd1);
  endtask

  initial begin
    int p0;
    reset = 1'b1;
    ifc.start = 1'b0; ifc.op = MD_MULT; ifc.rs = '0; ifc.rt = '0;
    repeat (2) @(posedge clk_cpu);
    chk_en = 1'b1;
    @(negedge clk_cpu);
    check("reset stall", 64'(ifc.stall), 64'd0);
    check("reset busy", 64'(ifc.busy), 64'd0);
    check("reset wr_en", 64'(ifc.hilo_wr_en), 64'd0);
    check("reset wr_data", ifc.hilo_wr_data, 64'd0);
    @(posedge clk_cpu); #1;
    reset = 1'b0;

    run_op("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op("mult -3*5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    run_op("mult -1*-1", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("div 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0);
    run_op("divu 100/7", MD_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0);
    run_op("divu by zero", MD_DIVU, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 1'b0);
    run_op("div -5 by zero", MD_DIV, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 1'b0);
    run_op("div min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
    run_op("multu disturbed", MD_MULTU, 32'd12345, 32'd678, 64'h0000_0000_007F_B6F6, 1'b1);

    // Reset in the middle of an operation: abort with no HI/LO write.
    p0 = wr_pulses;
    @(posedge clk_cpu); #1;
    ifc.start = 1'b1; ifc.op = MD_MULTU; ifc.rs = 32'd99; ifc.rt = 32'd77;
    repeat (10) @(posedge clk_cpu);
    #1;
    reset = 1'b1;
    ifc.start = 1'b0;
    @(posedge clk_cpu); #1;
    reset = 1'b0;
    @(negedge clk_cpu);
    check("abort stall", 64'(ifc.stall), 64'd0);
    check("abort busy", 64'(ifc.busy), 64'd0);
    check("abort wr_en", 64'(ifc.hilo_wr_en), 64'd0);
    repeat (40) @(negedge clk_cpu);
    check("abort no write", 64'(wr_pulses - p0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
